// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative AES-128 decryption engine.
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEXP, ADD, ROUND, FINAL, DONE} state_t;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine transform followed by the GF(2^8) inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] t;

  assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  assign y = gf_inv(t);
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box (as used by the encryption core): affine transform of the GF(2^8) inverse.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] t;

  assign t = gf_inv(a);
  assign y = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then ten inverse rounds
// one per cycle while the key schedule is unwound in place.
module aes_128_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);
  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] s;
  logic [127:0] k;
  logic [127:0] ct_reg;

  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;

  assign isr = inv_shift_rows(s);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isb (.a(isr[127-8*i -: 8]), .y(isb[127-8*i -: 8]));
  end

  assign ark = isb ^ k;
  assign imc = inv_mix_columns(ark);

  // One SubWord serves both directions: next() rotates w3, prev() rotates the recovered w3.
  logic [31:0]  sw_in;
  logic [31:0]  sw_out;
  logic [31:0]  rc_word;
  logic [127:0] k_next;
  logic [127:0] k_prev;

  assign sw_in   = (state == KEXP) ? rot_word(k[31:0]) : rot_word(k[31:0] ^ k[63:32]);
  assign rc_word = {rcon(cnt), 24'h0};

  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (.a(sw_in[31-8*i -: 8]), .y(sw_out[31-8*i -: 8]));
  end

  always_comb begin
    k_next = '0;
    k_prev = '0;
    k_next[127:96] = k[127:96] ^ sw_out ^ rc_word;
    k_next[95:64]  = k_next[127:96] ^ k[95:64];
    k_next[63:32]  = k_next[95:64] ^ k[63:32];
    k_next[31:0]   = k_next[63:32] ^ k[31:0];
    k_prev[31:0]   = k[31:0] ^ k[63:32];
    k_prev[63:32]  = k[63:32] ^ k[95:64];
    k_prev[95:64]  = k[95:64] ^ k[127:96];
    k_prev[127:96] = k[127:96] ^ sw_out ^ rc_word;
  end

  assign pt = s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      s         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ct_reg   <= ct;
            k        <= key;
            cnt      <= 4'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= KEXP;
          end
        end
        KEXP: begin
          k <= k_next;
          if (cnt == 4'd10) state <= ADD;
          else              cnt   <= cnt + 4'd1;
        end
        ADD: begin
          s     <= ct_reg ^ k;
          k     <= k_prev;
          cnt   <= 4'd9;
          state <= ROUND;
        end
        ROUND: begin
          s <= imc;
          k <= k_prev;
          if (cnt == 4'd1) state <= FINAL;
          else             cnt   <= cnt - 4'd1;
        end
        FINAL: begin
          s         <= ark;
          cnt       <= 4'd0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
